// File: rtl/tlb_mp_pkg.sv
// Shared definitions for the joint TLB: entrylo field layout and walker states.
package tlb_mp_pkg;

  // entrylo is packed {pfn, c[2:0], d, v}; offsets count from the LSB
  localparam int unsigned LoVBit   = 0;
  localparam int unsigned LoDBit   = 1;
  localparam int unsigned LoCLsb   = 2;
  localparam int unsigned LoPfnLsb = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StDone = 2'd2
  } inv_state_e;

endpackage

// File: rtl/tlb_mp_match.sv
// One TLB search port: per-entry match, lowest-index priority select,
// entrylo mux and exception flag generation. Purely combinational.
module tlb_mp_match
  import tlb_mp_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned VPN2W  = 19,
  parameter int unsigned ASIDW  = 8,
  parameter int unsigned LOW    = 25,
  parameter int unsigned IDXW   = 4
) (
  input  logic [VPN2W-1:0]              vpn2,
  input  logic                          odd_page,
  input  logic [ASIDW-1:0]              asid,
  input  logic                          store,
  input  logic [TLBNUM-1:0]             ent_valid,
  input  logic [TLBNUM-1:0]             ent_g,
  input  logic [TLBNUM-1:0][VPN2W-1:0]  ent_vpn2,
  input  logic [TLBNUM-1:0][ASIDW-1:0]  ent_asid,
  input  logic [TLBNUM-1:0][LOW-1:0]    ent_lo0,
  input  logic [TLBNUM-1:0][LOW-1:0]    ent_lo1,
  output logic                          found,
  output logic [IDXW-1:0]               index,
  output logic [LOW-1:0]                lo,
  output logic                          refill,
  output logic                          invalid,
  output logic                          modified
);

  logic [TLBNUM-1:0] hit;

  // Per-entry hit: valid, VPN2 equal, and global or same ASID
  always_comb begin
    for (int i = 0; i < int'(TLBNUM); i++) begin
      hit[i] = ent_valid[i] & (vpn2 == ent_vpn2[i]) & (ent_g[i] | (asid == ent_asid[i]));
    end
  end

  // Priority encode: scanning downwards leaves the lowest hit index
  always_comb begin
    index = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (hit[i]) index = IDXW'(i);
    end
  end

  // Entrylo select and exception flags
  always_comb begin
    found    = |hit;
    lo       = '0;
    if (found) lo = odd_page ? ent_lo1[index] : ent_lo0[index];
    refill   = ~found;
    invalid  = found & ~lo[LoVBit];
    modified = found & lo[LoVBit] & store & ~lo[LoDBit];
  end

endmodule

// File: rtl/tlb_mp.sv
// Multi-port joint TLB: entry storage, write/read ports, CP0 Random counter,
// registered search results and the invalidate walker.
module tlb_mp
  import tlb_mp_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned NPORTS = 2,
  parameter int unsigned VPN2W  = 19,
  parameter int unsigned ASIDW  = 8,
  parameter int unsigned PFNW   = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NPORTS-1:0]                    s_req,
  input  logic [NPORTS*VPN2W-1:0]              s_vpn2,
  input  logic [NPORTS-1:0]                    s_odd_page,
  input  logic [NPORTS*ASIDW-1:0]              s_asid,
  input  logic [NPORTS-1:0]                    s_store,
  output logic [NPORTS-1:0]                    s_rvalid,
  output logic [NPORTS-1:0]                    s_found,
  output logic [NPORTS*$clog2(TLBNUM)-1:0]     s_index,
  output logic [NPORTS*(PFNW+5)-1:0]           s_lo,
  output logic [NPORTS-1:0]                    s_refill,
  output logic [NPORTS-1:0]                    s_invalid,
  output logic [NPORTS-1:0]                    s_modified,
  input  logic                                 we,
  input  logic                                 w_random,
  input  logic [$clog2(TLBNUM)-1:0]            w_index,
  input  logic [VPN2W-1:0]                     w_vpn2,
  input  logic [ASIDW-1:0]                     w_asid,
  input  logic                                 w_g,
  input  logic [PFNW+4:0]                      w_lo0,
  input  logic [PFNW+4:0]                      w_lo1,
  input  logic [$clog2(TLBNUM)-1:0]            wired,
  output logic [$clog2(TLBNUM)-1:0]            random,
  input  logic [$clog2(TLBNUM)-1:0]            r_index,
  output logic [VPN2W-1:0]                     r_vpn2,
  output logic [ASIDW-1:0]                     r_asid,
  output logic                                 r_g,
  output logic [PFNW+4:0]                      r_lo0,
  output logic [PFNW+4:0]                      r_lo1,
  input  logic                                 inv_req,
  input  logic                                 inv_all,
  input  logic [ASIDW-1:0]                     inv_asid,
  output logic                                 inv_busy,
  output logic                                 inv_done
);

  localparam int unsigned IDXW = $clog2(TLBNUM);
  localparam int unsigned LOW  = PFNW + 5;
  localparam logic [IDXW-1:0] IdxMax = IDXW'(TLBNUM - 1);

  logic [TLBNUM-1:0]            ent_valid_q;
  logic [TLBNUM-1:0]            ent_g_q;
  logic [TLBNUM-1:0][VPN2W-1:0] ent_vpn2_q;
  logic [TLBNUM-1:0][ASIDW-1:0] ent_asid_q;
  logic [TLBNUM-1:0][LOW-1:0]   ent_lo0_q;
  logic [TLBNUM-1:0][LOW-1:0]   ent_lo1_q;

  logic [IDXW-1:0] random_q;
  logic [IDXW-1:0] w_idx;

  inv_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q;
  logic            inv_all_q;
  logic [ASIDW-1:0] inv_asid_q;
  logic            inv_clr;

  assign w_idx  = w_random ? random_q : w_index;
  assign random = random_q;

  // Entry payload is not reset; only the valid bits gate hits
  always_ff @(posedge clk) begin
    if (we) begin
      ent_vpn2_q[w_idx] <= w_vpn2;
      ent_asid_q[w_idx] <= w_asid;
      ent_g_q[w_idx]    <= w_g;
      ent_lo0_q[w_idx]  <= w_lo0;
      ent_lo1_q[w_idx]  <= w_lo1;
    end
  end

  // Valid bits: walker clear first so a same-entry write overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid_q <= '0;
    end else begin
      if (inv_clr) ent_valid_q[ptr_q] <= 1'b0;
      if (we)      ent_valid_q[w_idx] <= 1'b1;
    end
  end

  // CP0 Random: count down, reload at or below Wired
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= IdxMax;
    end else if (random_q <= wired) begin
      random_q <= IdxMax;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  // Read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpn2 <= '0;
      r_asid <= '0;
      r_g    <= 1'b0;
      r_lo0  <= '0;
      r_lo1  <= '0;
    end else begin
      r_vpn2 <= ent_vpn2_q[r_index];
      r_asid <= ent_asid_q[r_index];
      r_g    <= ent_g_q[r_index];
      r_lo0  <= ent_lo0_q[r_index];
      r_lo1  <= ent_lo1_q[r_index];
    end
  end

  // Search ports
  logic [NPORTS-1:0]           m_found, m_refill, m_invalid, m_modified;
  logic [NPORTS-1:0][IDXW-1:0] m_index;
  logic [NPORTS-1:0][LOW-1:0]  m_lo;

  for (genvar p = 0; p < int'(NPORTS); p++) begin : g_port
    tlb_mp_match #(
      .TLBNUM(TLBNUM),
      .VPN2W (VPN2W),
      .ASIDW (ASIDW),
      .LOW   (LOW),
      .IDXW  (IDXW)
    ) u_match (
      .vpn2     (s_vpn2[p*VPN2W +: VPN2W]),
      .odd_page (s_odd_page[p]),
      .asid     (s_asid[p*ASIDW +: ASIDW]),
      .store    (s_store[p]),
      .ent_valid(ent_valid_q),
      .ent_g    (ent_g_q),
      .ent_vpn2 (ent_vpn2_q),
      .ent_asid (ent_asid_q),
      .ent_lo0  (ent_lo0_q),
      .ent_lo1  (ent_lo1_q),
      .found    (m_found[p]),
      .index    (m_index[p]),
      .lo       (m_lo[p]),
      .refill   (m_refill[p]),
      .invalid  (m_invalid[p]),
      .modified (m_modified[p])
    );
  end

  // Register search results; hold them while no request is present
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rvalid   <= '0;
      s_found    <= '0;
      s_index    <= '0;
      s_lo       <= '0;
      s_refill   <= '0;
      s_invalid  <= '0;
      s_modified <= '0;
    end else begin
      s_rvalid <= s_req;
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (s_req[p]) begin
          s_found[p]              <= m_found[p];
          s_index[p*IDXW +: IDXW] <= m_index[p];
          s_lo[p*LOW +: LOW]      <= m_lo[p];
          s_refill[p]             <= m_refill[p];
          s_invalid[p]            <= m_invalid[p];
          s_modified[p]           <= m_modified[p];
        end
      end
    end
  end

  assign inv_clr = (state_q == StWalk) &
                   (inv_all_q | (~ent_g_q[ptr_q] & (ent_asid_q[ptr_q] == inv_asid_q)));

  // Walker state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Walker pointer and target capture, sampled only on leaving idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      inv_all_q  <= 1'b0;
      inv_asid_q <= '0;
    end else if (state_q == StIdle && inv_req) begin
      ptr_q      <= '0;
      inv_all_q  <= inv_all;
      inv_asid_q <= inv_asid;
    end else if (state_q == StWalk) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  // Walker next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (inv_req) state_d = StWalk;
      StWalk:  if (ptr_q == IdxMax) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Walker outputs
  always_comb begin
    inv_busy = (state_q == StWalk);
    inv_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_tlb_mp.sv
// Self-checking bench for tlb_mp: vector table for lookups, scoreboard queue
// for registered results, hand sequences for random, write/read timing and walker.
module tb_tlb_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_req, s_odd_page, s_store;
  logic [37:0] s_vpn2;
  logic [15:0] s_asid;
  logic [1:0]  s_rvalid, s_found, s_refill, s_invalid, s_modified;
  logic [7:0]  s_index;
  logic [49:0] s_lo;
  logic        we, w_random, w_g;
  logic [3:0]  w_index, wired, random, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0]  w_asid, r_asid, inv_asid;
  logic [24:0] w_lo0, w_lo1, r_lo0, r_lo1;
  logic        r_g, inv_req, inv_all, inv_busy, inv_done;

  tlb_mp dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_store(s_store), .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index),
    .s_lo(s_lo), .s_refill(s_refill), .s_invalid(s_invalid), .s_modified(s_modified),
    .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
    .w_g(w_g), .w_lo0(w_lo0), .w_lo1(w_lo1), .wired(wired), .random(random),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_lo0(r_lo0),
    .r_lo1(r_lo1), .inv_req(inv_req), .inv_all(inv_all), .inv_asid(inv_asid),
    .inv_busy(inv_busy), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [18:0] vpn;
    logic        odd;
    logic [7:0]  asid;
    logic        st;
    logic        found;
    logic [3:0]  idx;
    logic [24:0] lo;
    logic        refill;
    logic        invalid;
    logic        modified;
  } vec_t;

  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [24:0] LoA1 = {20'hABCDE, 3'd3, 1'b0, 1'b1};
  localparam logic [24:0] LoA0 = {20'h11111, 3'd3, 1'b1, 1'b1};
  localparam logic [24:0] LoG2 = {20'h22222, 3'd2, 1'b1, 1'b1};
  localparam logic [24:0] LoG7 = {20'h77777, 3'd2, 1'b1, 1'b1};
  localparam logic [24:0] LoI  = {20'h99999, 3'd0, 1'b0, 1'b0};
  localparam logic [24:0] LoR  = {20'h0E0E0, 3'd1, 1'b1, 1'b1};
  localparam logic [24:0] LoW  = {20'h0C0DE, 3'd3, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare any results the DUT presents against the scoreboard
  task automatic drain();
    vec_t e;
    for (int p = 0; p < 2; p++) begin
      if (s_rvalid[p]) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected rvalid p%0d", p), 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result port", p, e.port);
          chk($sformatf("found p%0d vpn %0h", p, e.vpn), s_found[p], e.found);
          chk($sformatf("refill p%0d vpn %0h", p, e.vpn), s_refill[p], e.refill);
          if (e.found) begin
            chk($sformatf("index p%0d vpn %0h", p, e.vpn), s_index[p*4 +: 4], e.idx);
            chk($sformatf("lo p%0d vpn %0h", p, e.vpn), s_lo[p*25 +: 25], e.lo);
            chk($sformatf("invalid p%0d vpn %0h", p, e.vpn), s_invalid[p], e.invalid);
            chk($sformatf("modified p%0d vpn %0h", p, e.vpn), s_modified[p], e.modified);
          end
        end
      end
    end
    if (sb.size() != 0) begin
      chk("missing rvalid", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One clock: sample after the edge, then drop single-cycle pulses
  task automatic step();
    @(posedge clk);
    #1;
    drain();
    s_req   = '0;
    we      = 1'b0;
    inv_req = 1'b0;
  endtask

  task automatic lookup(input vec_t v);
    s_req[v.port]               = 1'b1;
    s_vpn2[v.port*19 +: 19]     = v.vpn;
    s_odd_page[v.port]          = v.odd;
    s_asid[v.port*8 +: 8]       = v.asid;
    s_store[v.port]             = v.st;
    sb.push_back(v);
  endtask

  task automatic wr(input logic [3:0] idx, input logic rnd, input logic [18:0] vpn,
                    input logic [7:0] asid, input logic g, input logic [24:0] lo0,
                    input logic [24:0] lo1);
    we = 1'b1; w_random = rnd; w_index = idx; w_vpn2 = vpn; w_asid = asid; w_g = g;
    w_lo0 = lo0; w_lo1 = lo1;
  endtask

  function automatic vec_t mk(input int port, input logic [18:0] vpn, input logic odd,
                              input logic [7:0] asid, input logic st, input logic found,
                              input logic [3:0] idx, input logic [24:0] lo,
                              input logic inv, input logic mod);
    vec_t v;
    v.port = port; v.vpn = vpn; v.odd = odd; v.asid = asid; v.st = st;
    v.found = found; v.idx = idx; v.lo = lo; v.refill = ~found;
    v.invalid = inv; v.modified = mod;
    return v;
  endfunction

  vec_t vecs[8];
  vec_t post[5];
  int   n;

  initial begin
    rst = 1'b1; s_req = '0; s_vpn2 = '0; s_odd_page = '0; s_asid = '0; s_store = '0;
    we = 1'b0; w_random = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_lo0 = '0; w_lo1 = '0; wired = '0; r_index = '0;
    inv_req = 1'b0; inv_all = 1'b0; inv_asid = '0;

    vecs[0] = mk(1, 19'h12345, 1, 8'd5,    1, 1, 4'd3, LoA1, 0, 1);
    vecs[1] = mk(0, 19'h12345, 1, 8'd5,    0, 1, 4'd3, LoA1, 0, 0);
    vecs[2] = mk(0, 19'h12345, 0, 8'd5,    1, 1, 4'd3, LoA0, 0, 0);
    vecs[3] = mk(1, 19'h12345, 1, 8'd6,    0, 0, 4'd0, '0,   0, 0);
    vecs[4] = mk(0, 19'h2AAAA, 0, 8'h33,   0, 1, 4'd2, LoG2, 0, 0);
    vecs[5] = mk(1, 19'h2AAAA, 0, 8'd1,    1, 1, 4'd2, LoG2, 0, 0);
    vecs[6] = mk(0, 19'h00100, 0, 8'd5,    0, 1, 4'd9, LoI,  1, 0);
    vecs[7] = mk(1, 19'h00100, 0, 8'd5,    1, 1, 4'd9, LoI,  1, 0);

    // Reset state
    step(); step();
    chk("reset rvalid", s_rvalid, 0);
    chk("reset found", s_found, 0);
    chk("reset refill", s_refill, 0);
    chk("reset busy", inv_busy, 0);
    chk("reset done", inv_done, 0);
    chk("reset random", random, 15);
    chk("reset r_vpn2", r_vpn2, 0);
    rst = 1'b0;

    // Empty TLB misses
    lookup(mk(0, 19'h00001, 0, 8'd0, 0, 0, 4'd0, '0, 0, 0));
    step();

    wr(4'd3, 0, 19'h12345, 8'd5, 0, LoA0, LoA1);                  step();
    wr(4'd7, 0, 19'h2AAAA, 8'd1, 1, LoG7, LoG7);                  step();
    wr(4'd2, 0, 19'h2AAAA, 8'd9, 1, LoG2, LoG2);                  step();
    wr(4'd9, 0, 19'h00100, 8'd5, 0, LoI, LoI);                    step();

    for (int i = 0; i < 8; i++) begin
      lookup(vecs[i]);
      step();
    end
    // Results hold while no request
    step();
    chk("hold rvalid", s_rvalid[1], 0);
    chk("hold found", s_found[1], 1);
    chk("hold index", s_index[7:4], 9);
    chk("hold invalid", s_invalid[1], 1);

    // Both ports in the same cycle
    lookup(vecs[4]);
    lookup(vecs[0]);
    step();

    // Write and lookup together: lookup sees the old entry
    wr(4'd3, 0, 19'h0ABCD, 8'd5, 0, LoA0, LoA1);
    lookup(vecs[1]);
    step();
    lookup(mk(0, 19'h12345, 1, 8'd5, 0, 0, 4'd0, '0, 0, 0));
    step();
    lookup(mk(1, 19'h0ABCD, 1, 8'd5, 1, 1, 4'd3, LoA1, 0, 1));
    step();

    // Read port
    r_index = 4'd2;
    step();
    chk("read vpn2", r_vpn2, 19'h2AAAA);
    chk("read asid", r_asid, 9);
    chk("read g", r_g, 1);
    chk("read lo0", r_lo0, LoG2);

    // Random with wired=4: 15..4 then reload to 15
    wired = 4'd4;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("random k=%0d", k), random, (k <= 11) ? 15 - k : 15 - (k - 12));
      if (k < 13) step();
    end
    // random is 14 in this cycle
    wr(4'd0, 1, 19'h05555, 8'd0, 1, LoR, LoR);
    step();
    lookup(mk(0, 19'h05555, 0, 8'd0, 0, 1, 4'd14, LoR, 0, 0));
    step();
    wired = 4'd0;

    // Invalidate by ASID
    wr(4'd0, 0, 19'h01000, 8'd5, 0, LoW, LoW); step();
    wr(4'd4, 0, 19'h01004, 8'd5, 0, LoW, LoW); step();
    wr(4'd1, 0, 19'h01001, 8'd5, 1, LoW, LoW); step();
    wr(4'd5, 0, 19'h01002, 8'd6, 0, LoW, LoW); step();
    inv_req = 1'b1; inv_all = 1'b0; inv_asid = 8'd5;
    step();
    n = 1;
    chk("walk busy", inv_busy, 1);
    inv_asid = 8'd6;
    // Rewrite entry 0 while the walker is clearing it
    wr(4'd0, 0, 19'h01000, 8'd5, 0, LoW, LoW);
    while (!inv_done && n < 40) begin
      if (n == 8) inv_req = 1'b1;
      if (n == 10) lookup(mk(1, 19'h05555, 0, 8'd7, 0, 1, 4'd14, LoR, 0, 0));
      step();
      n++;
    end
    chk("inv_done latency", n, 17);
    step();
    chk("inv_done pulse", inv_done, 0);
    chk("busy after done", inv_busy, 0);

    post[0] = mk(0, 19'h01000, 0, 8'd5, 0, 1, 4'd0,  LoW, 0, 0);
    post[1] = mk(1, 19'h01004, 0, 8'd5, 0, 0, 4'd0,  '0,  0, 0);
    post[2] = mk(0, 19'h01001, 0, 8'd5, 0, 1, 4'd1,  LoW, 0, 0);
    post[3] = mk(1, 19'h01002, 0, 8'd6, 0, 1, 4'd5,  LoW, 0, 0);
    post[4] = mk(0, 19'h05555, 0, 8'd5, 0, 1, 4'd14, LoR, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lookup(post[i]);
      step();
    end

    // Reset in the middle of an invalidate-all walk
    inv_req = 1'b1; inv_all = 1'b1;
    step();
    n = 1;
    while (n < 6) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    chk("mid-walk rst busy", inv_busy, 0);
    chk("mid-walk rst done", inv_done, 0);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (inv_done) n++;
    end
    chk("no inv_done after rst", n, 0);
    lookup(mk(0, 19'h01001, 0, 8'd5, 0, 0, 4'd0, '0, 0, 0));
    lookup(mk(1, 19'h05555, 0, 8'd0, 0, 0, 4'd0, '0, 0, 0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
